// File: rtl/alu_shift_sequencer.sv
// alu_shift_sequencer: multi-cycle shift/rotate unit, one bit position per clock through a 1-bit shifter
module alu_shift_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   start,
  input  logic [2:0]             op,
  input  logic [DATA_WIDTH-1:0]  input_data,
  input  logic [COUNT_WIDTH-1:0] num_shifts,
  output logic                   busy,
  output logic                   done,
  output logic                   op_err,
  output logic [DATA_WIDTH-1:0]  result_data
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] work, work_nx, step;
  logic [COUNT_WIDTH-1:0] count, count_nx;
  logic [2:0] op_q, op_nx;
  logic accept;
  assign accept = state == IDLE && start && op <= 3'd4;
  always_comb
    step = op_q == 3'd0 ? {1'b0, work[DATA_WIDTH-1:1]} :
           op_q == 3'd1 ? {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]} :
           op_q == 3'd2 ? {work[DATA_WIDTH-2:0], 1'b0} :
           op_q == 3'd3 ? {work[0], work[DATA_WIDTH-1:1]} :
                          {work[DATA_WIDTH-2:0], work[DATA_WIDTH-1]};
  always_comb begin
    state_nx = state;
    work_nx  = work;
    count_nx = count;
    op_nx    = op_q;
    case (state)
      IDLE: if (accept) begin
        work_nx  = input_data;
        count_nx = num_shifts;
        op_nx    = op;
        state_nx = num_shifts != '0 ? RUN : DONE;
      end
      RUN: begin
        work_nx  = step;
        count_nx = count - 1'b1;
        state_nx = count == COUNT_WIDTH'(1) ? DONE : RUN;
      end
      default: state_nx = IDLE;
    endcase
  end
  // result is loaded on the edge entering DONE so it is valid alongside done
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state       <= IDLE;
      work        <= '0;
      count       <= '0;
      op_q        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      op_err      <= 1'b0;
      result_data <= '0;
    end else begin
      state  <= state_nx;
      work   <= work_nx;
      count  <= count_nx;
      op_q   <= op_nx;
      busy   <= state_nx == RUN;
      done   <= state_nx == DONE;
      op_err <= state == IDLE && start && op > 3'd4;
      if (state_nx == DONE) result_data <= work_nx;
    end
  end
endmodule

// File: tb/tb_alu_shift_sequencer.sv
// tb_alu_shift_sequencer: vector table, directed corner sequences and random ops against a behavioural model
module tb_alu_shift_sequencer;
  logic clk = 0, clr_n = 0, start = 0;
  logic [2:0] op = 0;
  logic [31:0] input_data = 0;
  logic [4:0] num_shifts = 0;
  logic busy, done, op_err;
  logic [31:0] result_data;
  int checks = 0, failures = 0;

  alu_shift_sequencer dut (
    .clk(clk), .clr_n(clr_n), .start(start), .op(op), .input_data(input_data),
    .num_shifts(num_shifts), .busy(busy), .done(done), .op_err(op_err), .result_data(result_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  o;
    logic [31:0] d;
    logic [4:0]  n;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] d, input logic [4:0] n);
    logic [63:0] dd;
    logic [31:0] r;
    case (o)
      3'd0: r = d >> n;
      3'd1: r = 32'($signed(d) >>> n);
      3'd2: r = d << n;
      3'd3: begin dd = {d, d} >> n; r = dd[31:0]; end
      default: begin dd = {d, d} << n; r = dd[63:32]; end
    endcase
    return r;
  endfunction

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while ((busy || done) && g < 100) begin @(negedge clk); g++; end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] d, input logic [4:0] n,
                        output logic [31:0] r, output int edges, output int busy_cyc, output bit overlap);
    wait_idle();
    start = 1; op = o; input_data = d; num_shifts = n;
    @(posedge clk); #1;
    start = 0; op = $urandom_range(0, 4); input_data = $urandom; num_shifts = 5'($urandom);
    edges = 1; busy_cyc = 0; overlap = 0;
    while (!done && edges < 100) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      edges++;
    end
    overlap = done && busy;
    r = result_data;
  endtask

  initial begin
    logic [31:0] r, e;
    int edges, bc, dcnt;
    bit ov;
    vt[0]  = '{3'd3, 32'h80000001, 5'd1,  32'hC0000000};
    vt[1]  = '{3'd4, 32'h12345678, 5'd31, 32'h091A2B3C};
    vt[2]  = '{3'd1, 32'h80000000, 5'd4,  32'hF8000000};
    vt[3]  = '{3'd0, 32'h80000000, 5'd4,  32'h08000000};
    vt[4]  = '{3'd2, 32'h0000FFFF, 5'd16, 32'hFFFF0000};
    vt[5]  = '{3'd0, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
    vt[6]  = '{3'd1, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
    vt[7]  = '{3'd2, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
    vt[8]  = '{3'd3, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
    vt[9]  = '{3'd4, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
    vt[10] = '{3'd2, 32'h00000001, 5'd31, 32'h80000000};

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_op_err", 32'(op_err), 0);
    check("reset_result", result_data, 0);
    clr_n = 1;

    foreach (vt[i]) begin
      run_op(vt[i].o, vt[i].d, vt[i].n, r, edges, bc, ov);
      check($sformatf("vec%0d_result", i), r, vt[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(edges), 32'(vt[i].n) + 1);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(vt[i].n));
      check($sformatf("vec%0d_overlap", i), 32'(ov), 0);
    end

    for (int i = 0; i < 30; i++) begin
      logic [2:0] o;
      logic [31:0] d;
      logic [4:0] n;
      o = 3'($urandom_range(0, 4)); d = $urandom; n = 5'($urandom_range(0, 31));
      run_op(o, d, n, r, edges, bc, ov);
      check($sformatf("rand%0d_op%0d_n%0d_result", i, o, n), r, model(o, d, n));
      check($sformatf("rand%0d_latency", i), 32'(edges), 32'(n) + 1);
    end

    // start held through RUN and DONE with new operands: only the IDLE cycle accepts it
    wait_idle();
    start = 1; op = 3'd2; input_data = 32'h1; num_shifts = 5'd3;
    @(posedge clk); #1;
    op = 3'd3; input_data = 32'h000000F0; num_shifts = 5'd4;
    edges = 1;
    while (!done && edges < 50) begin @(posedge clk); #1; edges++; end
    check("ign_latency", 32'(edges), 4);
    check("ign_result", result_data, 32'h8);
    @(posedge clk); #1;
    check("ign_done_cycle_busy", 32'(busy), 0);
    check("ign_done_cycle_done", 32'(done), 0);
    @(posedge clk); #1;
    start = 0;
    check("ign_reaccept_busy", 32'(busy), 1);
    edges = 1;
    while (!done && edges < 50) begin @(posedge clk); #1; edges++; end
    check("ign_second_latency", 32'(edges), 5);
    check("ign_second_result", result_data, 32'h0000000F);

    wait_idle();
    start = 1; op = 3'd5; input_data = 32'h12345678; num_shifts = 5'd2;
    @(posedge clk); #1;
    start = 0;
    check("illegal_op_err", 32'(op_err), 1);
    check("illegal_busy", 32'(busy), 0);
    check("illegal_done", 32'(done), 0);
    @(posedge clk); #1;
    check("illegal_op_err_pulse", 32'(op_err), 0);
    check("illegal_result_kept", result_data, 32'h0000000F);
    dcnt = 0;
    repeat (4) begin @(posedge clk); #1; dcnt += int'(done || busy); end
    check("illegal_no_activity", 32'(dcnt), 0);

    wait_idle();
    start = 1; op = 3'd2; input_data = 32'h00000123; num_shifts = 5'd10;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); clr_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); clr_n = 1;
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_result", result_data, 0);
    dcnt = 0;
    repeat (15) begin @(posedge clk); #1; dcnt += int'(done); end
    check("rst_mid_no_done", 32'(dcnt), 0);
    check("rst_mid_result_after", result_data, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
